// File: rtl/sram_stream_reader.sv
// Read-side sequencer for the LSTM weight/state SRAM: issues burst reads and
// streams the returned words through a 2-entry credit-managed output buffer.
module sram_stream_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 112
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iStart,
    input  logic [ADDR_W-1:0] iBase_addr,
    input  logic [ADDR_W:0]   iLen,
    output logic              oBusy,
    output logic              oDone,
    output logic              oR_en,
    output logic [ADDR_W-1:0] oR_addr,
    input  logic [DATA_W-1:0] iD_in,
    output logic              oValid,
    output logic [DATA_W-1:0] oData,
    output logic              oLast,
    input  logic              iReady
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remain;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [1:0]        r_count;
    logic              r_valid;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic              r_last0;
    logic              r_last1;

    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_credit_use;
    logic              w_issue;
    logic              w_issue_last;

    assign w_pop  = r_valid & iReady;
    assign w_push = r_inflight;

    // Credit check includes this cycle's pop so a freed slot is reused with
    // no bubble; pop implies r_count >= 1, so the subtraction cannot wrap.
    assign w_credit_use = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // NOTE: the read strobe combines registered credit state with the live pop,
    // which is what lets a single-cycle read loop sustain one word per cycle.
    assign w_issue      = (r_state == ST_RUN) && (r_remain != '0) && (w_credit_use < 3'd2);
    assign w_issue_last = w_issue && (r_remain == LEN_ONE);

    assign oBusy   = r_busy;
    assign oDone   = r_done;
    assign oR_en   = w_issue;
    assign oR_addr = r_addr;
    assign oValid  = r_valid;
    assign oData   = r_data0;
    assign oLast   = r_last0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_addr          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_count         <= 2'd0;
            r_valid         <= 1'b0;
            // NOTE: buffer words are reset too, because oData must read 0 out of reset.
            r_data0         <= '0;
            r_data1         <= '0;
            r_last0         <= 1'b0;
            r_last1         <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;

            if (w_issue) begin
                r_addr   <= r_addr + ADDR_ONE;
                r_remain <= r_remain - LEN_ONE;
            end

            case (r_state)
                ST_IDLE: begin
                    if (iStart && (iLen != '0)) begin
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                        r_addr   <= iBase_addr;
                        r_remain <= iLen;
                    end
                end
                ST_RUN: begin
                    if (w_issue_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && r_last0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Head entry drives the stream; the tail shifts forward on a pop.
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= iD_in;
                        r_last0 <= r_inflight_last;
                    end else begin
                        r_data1 <= iD_in;
                        r_last1 <= r_inflight_last;
                    end
                    r_count <= r_count + 2'd1;
                    r_valid <= 1'b1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                    end else begin
                        r_last0 <= 1'b0;
                        r_valid <= 1'b0;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= iD_in;
                        r_last0 <= r_inflight_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= iD_in;
                        r_last1 <= r_inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: an SRAM model feeds the DUT and a
// burst-level reference (address/word order, credit rule, timing) checks it.
module tb_sram_stream_reader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 112;

    logic              clk = 1'b0;
    logic              rst;
    logic              iStart;
    logic [ADDR_W-1:0] iBase_addr;
    logic [ADDR_W:0]   iLen;
    logic              oBusy;
    logic              oDone;
    logic              oR_en;
    logic [ADDR_W-1:0] oR_addr;
    logic [DATA_W-1:0] iD_in;
    logic              oValid;
    logic [DATA_W-1:0] oData;
    logic              oLast;
    logic              iReady;

    sram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .iStart     (iStart),
        .iBase_addr (iBase_addr),
        .iLen       (iLen),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oR_en      (oR_en),
        .oR_addr    (oR_addr),
        .iD_in      (iD_in),
        .oValid     (oValid),
        .oData      (oData),
        .oLast      (oLast),
        .iReady     (iReady)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [256];

    function automatic logic [DATA_W-1:0] rand_word();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    // SRAM macro model: one-cycle read latency, garbage when not reading.
    always @(posedge clk) begin
        if (oR_en) iD_in <= mem[oR_addr];
        else       iD_in <= rand_word();
    end

    int n_asserts = 0;
    int n_fail    = 0;

    // Burst reference state
    bit          b_active;
    logic [7:0]  b_base;
    int          b_len;
    int          n_reads;
    int          n_words;
    bit          done_seen;
    int          occ;
    bit          prev_ren;
    bit          prev_stall;
    logic [DATA_W-1:0] prev_data;

    // Sampled outputs of the current cycle
    logic s_ren, s_valid, s_last, s_done, s_busy;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_burst(input logic [7:0] base, input int len);
        b_active  = 1'b1;
        b_base    = base;
        b_len     = len;
        n_reads   = 0;
        n_words   = 0;
        done_seen = 1'b0;
    endtask

    task automatic reset_model();
        occ        = 0;
        prev_ren   = 1'b0;
        prev_stall = 1'b0;
        b_active   = 1'b0;
    endtask

    // Per-cycle monitor, called at the falling edge.
    task automatic monitor();
        logic       pop;
        logic [7:0] ea;
        pop = oValid && iReady;
        s_ren = oR_en; s_valid = oValid; s_last = oLast; s_done = oDone;
        s_busy = oBusy; s_addr = oR_addr; s_data = oData;

        check("valid_vs_occupancy", oValid, occ != 0);
        if (oR_en) begin
            check("credit_rule", (occ + int'(prev_ren) - int'(pop)) < 2, 1'b1);
            check("read_expected", b_active && (n_reads < b_len), 1'b1);
            ea = b_base + 8'(n_reads);
            check_w("read_addr", DATA_W'(oR_addr), DATA_W'(ea));
            n_reads++;
        end
        if (prev_stall) begin
            check("stall_valid", oValid, 1'b1);
            check_w("stall_data", oData, prev_data);
        end
        if (pop) begin
            check("word_expected", b_active && (n_words < b_len), 1'b1);
            ea = b_base + 8'(n_words);
            check_w("stream_data", oData, mem[ea]);
            check("stream_last", oLast, n_words == b_len - 1);
            n_words++;
        end
        if (oDone) done_seen = 1'b1;
        occ        = occ + int'(prev_ren) - int'(pop);
        prev_ren   = oR_en;
        prev_stall = oValid && !iReady;
        prev_data  = oData;
        check("occupancy_bound", occ <= 2, 1'b1);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // mode 0: iReady=1 with exact timing checks; 1: fixed stall pattern; 2: random.
    task automatic run_burst(input logic [7:0] base, input logic [8:0] len, input int mode,
                             input bit started, input bit mid_start, input bit chain,
                             input logic [7:0] nbase, input logic [8:0] nlen);
        int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int c;
        int budget;
        int L;
        L = int'(len);
        begin_burst(base, L);
        budget = 8 * L + 20;
        c = started ? 1 : 0;
        while (!done_seen && c < budget) begin
            iStart = 1'b0;
            if (c == 0) begin
                iStart = 1'b1; iBase_addr = base; iLen = len;
            end
            if (mid_start && c == 3) begin
                iStart = 1'b1; iBase_addr = 8'h99; iLen = 9'd7;
            end
            if (chain && c == L + 3) begin
                iStart = 1'b1; iBase_addr = nbase; iLen = nlen;
            end
            case (mode)
                0:       iReady = 1'b1;
                1:       iReady = (pat[c % 7] != 0);
                default: iReady = ($urandom_range(0, 3) != 0);
            endcase
            tick();
            if (mode == 0) begin
                check("t_ren",   s_ren,   c >= 1 && c <= L);
                check("t_valid", s_valid, c >= 3 && c <= L + 2);
                check("t_last",  s_last,  c == L + 2);
                check("t_done",  s_done,  c == L + 3);
                check("t_busy",  s_busy,  c >= 1 && c <= L + 2);
            end
            c++;
        end
        iStart = 1'b0;
        check("done_seen", done_seen, 1'b1);
        check("read_total", n_reads == L, 1'b1);
        check("word_total", n_words == L, 1'b1);
        check("busy_clear_at_done", s_busy, 1'b0);
        b_active = 1'b0;
    endtask

    initial begin
        rst = 1'b1; iStart = 1'b0; iBase_addr = '0; iLen = '0; iReady = 1'b0;
        reset_model();
        for (int i = 0; i < 256; i++) mem[i] = DATA_W'(i);
        repeat (3) @(posedge clk);
        #1;
        tick();
        check("rst_busy", s_busy, 1'b0);
        check("rst_done", s_done, 1'b0);
        check("rst_ren", s_ren, 1'b0);
        check_w("rst_addr", DATA_W'(s_addr), '0);
        check("rst_valid", s_valid, 1'b0);
        check_w("rst_data", s_data, '0);
        check("rst_last", s_last, 1'b0);
        rst = 1'b0;

        // Basic burst with SRAM[i] = i
        run_burst(8'h10, 9'd4, 0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0);

        for (int i = 0; i < 256; i++) mem[i] = rand_word();

        // Address wrap-around
        run_burst(8'hFE, 9'd4, 0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0);
        // Backpressure pattern
        run_burst(8'h30, 9'd8, 1, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0);
        // Start while busy is ignored
        run_burst(8'h50, 9'd6, 0, 1'b0, 1'b1, 1'b0, 8'h00, 9'd0);

        // Zero-length start is ignored
        iStart = 1'b1; iBase_addr = 8'h44; iLen = '0; iReady = 1'b1;
        tick();
        iStart = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("len0_busy", s_busy, 1'b0);
            check("len0_ren", s_ren, 1'b0);
        end

        // Back-to-back bursts, second accepted in the oDone cycle
        run_burst(8'h40, 9'd3, 0, 1'b0, 1'b0, 1'b1, 8'h80, 9'd5);
        run_burst(8'h80, 9'd5, 0, 1'b1, 1'b0, 1'b0, 8'h00, 9'd0);

        // Randomized bursts with random backpressure
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) mem[i] = rand_word();
            run_burst(8'($urandom_range(0, 255)), 9'($urandom_range(1, 40)), 2,
                      1'b0, 1'b0, 1'b0, 8'h00, 9'd0);
        end

        // Full memory sweep
        run_burst(8'h00, 9'd256, 0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0);

        // Reset mid-burst in cycle 6
        begin_burst(8'h60, 16);
        iReady = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            iStart = (c == 0);
            iBase_addr = 8'h60; iLen = 9'd16;
            rst = (c == 6);
            tick();
        end
        rst = 1'b0;
        reset_model();
        tick();
        check("mid_rst_busy", s_busy, 1'b0);
        check("mid_rst_done", s_done, 1'b0);
        check("mid_rst_ren", s_ren, 1'b0);
        check_w("mid_rst_addr", DATA_W'(s_addr), '0);
        check("mid_rst_valid", s_valid, 1'b0);
        check_w("mid_rst_data", s_data, '0);
        check("mid_rst_last", s_last, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_rst_no_done", s_done, 1'b0);
            check("mid_rst_no_valid", s_valid, 1'b0);
        end
        run_burst(8'h20, 9'd2, 0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
